// File: rtl/dht11_sched_pkg.sv
// Shared encodings, counter width and default timing for the DHT11 capture scheduler.
package dht11_sched_pkg;

    localparam int CNT_W = 16;

    localparam int DEF_MIN_GAP_MS     = 2000;
    localparam int DEF_AUTO_PERIOD_MS = 8000;
    localparam int DEF_TIMEOUT_MS     = 50;
    localparam int DEF_RST_MS         = 5;
    localparam int DEF_MAX_RETRY      = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond counter: clear beats count, counts tick_i while en_i, then holds at
// limit_i (WRAP=0) or returns to 0 on the next tick (WRAP=1); term_o = count at limit.
module ms_timer
    import dht11_sched_pkg::*;
#(
    parameter bit WRAP = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && tick_i) begin
            if (cnt_q == limit_i) begin
                cnt_d = WRAP ? '0 : cnt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == limit_i);

endmodule

// File: rtl/dht11_capture_scheduler.sv
// Merges manual/auto capture requests, enforces the inter-read gap, supervises each DHT11
// read with timeout + driver reset + retry. Optional counters: DHT11_SCHED_STATS_EN.
module dht11_capture_scheduler
    import dht11_sched_pkg::*;
#(
    parameter int MIN_GAP_MS     = DEF_MIN_GAP_MS,
    parameter int AUTO_PERIOD_MS = DEF_AUTO_PERIOD_MS,
    parameter int TIMEOUT_MS     = DEF_TIMEOUT_MS,
    parameter int RST_MS         = DEF_RST_MS,
    parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_ms,
    input  logic       auto_en,
    input  logic       man_req,
    output logic       drv_start,
    output logic       drv_rst_n,
    input  logic       drv_done,
    input  logic       drv_err,
    input  logic [7:0] drv_humid,
    input  logic [7:0] drv_temp,
    output logic [7:0] humid_q,
    output logic [7:0] temp_q,
    output logic       data_valid,
    output logic       busy,
    output logic       err_sticky,
    output logic [7:0] ok_cnt,
    output logic [7:0] err_cnt
);

    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(MIN_GAP_MS);
    localparam logic [CNT_W-1:0] AUTO_LIM = CNT_W'(AUTO_PERIOD_MS - 1);
    localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT_MS);
    localparam logic [CNT_W-1:0] RST_LIM  = CNT_W'(RST_MS);
    localparam logic [7:0]       RETRY_LIM = 8'(MAX_RETRY);

    state_t     state_q, state_d;
    logic       man_prev_q, man_pend_q, man_pend_d;
    logic       auto_pend_q, auto_pend_d;
    logic       retry_pend_q, retry_pend_d;
    logic [7:0] retry_cnt_q, retry_cnt_d;
    logic [7:0] humid_d, temp_d;
    logic       data_valid_d, err_sticky_d;
    logic       drv_rst_n_q, drv_rst_n_d;

    logic gap_ok, auto_term, to_term, rst_term;
    logic auto_wrap, rd_ok, rd_fail, rec_exit, can_retry;

    ms_timer #(.WRAP(1'b0)) u_gap (
        .clk(clk), .rst_n(rst_n), .tick_i(tick_ms),
        .clr_i(state_q == ST_START), .en_i(1'b1),
        .limit_i(GAP_LIM), .term_o(gap_ok)
    );

    ms_timer #(.WRAP(1'b1)) u_auto (
        .clk(clk), .rst_n(rst_n), .tick_i(tick_ms),
        .clr_i(!auto_en), .en_i(auto_en),
        .limit_i(AUTO_LIM), .term_o(auto_term)
    );

    ms_timer #(.WRAP(1'b0)) u_timeout (
        .clk(clk), .rst_n(rst_n), .tick_i(tick_ms),
        .clr_i(state_q == ST_START), .en_i(state_q == ST_WAIT),
        .limit_i(TO_LIM), .term_o(to_term)
    );

    ms_timer #(.WRAP(1'b0)) u_recover (
        .clk(clk), .rst_n(rst_n), .tick_i(tick_ms),
        .clr_i(state_q != ST_RECOVER), .en_i(state_q == ST_RECOVER),
        .limit_i(RST_LIM), .term_o(rst_term)
    );

    assign auto_wrap = auto_en && tick_ms && auto_term;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A good drv_done wins over a timeout landing on the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if ((man_pend_q || auto_pend_q || retry_pend_q) && gap_ok) begin
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (drv_done && !drv_err) begin
                    state_d = ST_IDLE;
                end else if (drv_done || to_term) begin
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (rst_term) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        drv_start = (state_q == ST_START);
        busy      = (state_q != ST_IDLE);
    end

    assign drv_rst_n = drv_rst_n_q;

    assign rd_ok     = (state_q == ST_WAIT) && drv_done && !drv_err;
    assign rd_fail   = (state_q == ST_WAIT) && (state_d == ST_RECOVER);
    assign rec_exit  = (state_q == ST_RECOVER) && rst_term;
    assign can_retry = (retry_cnt_q < RETRY_LIM);

    // Newly arriving requests take priority over the clear in START so none are lost.
    always_comb begin
        man_pend_d   = man_pend_q;
        auto_pend_d  = auto_pend_q;
        retry_pend_d = retry_pend_q;
        retry_cnt_d  = retry_cnt_q;
        humid_d      = humid_q;
        temp_d       = temp_q;
        data_valid_d = data_valid;
        err_sticky_d = err_sticky;

        if (state_q == ST_START) begin
            man_pend_d   = 1'b0;
            auto_pend_d  = 1'b0;
            retry_pend_d = 1'b0;
        end
        if (man_req && !man_prev_q) man_pend_d = 1'b1;
        if (auto_wrap)              auto_pend_d = 1'b1;
        if (!auto_en)               auto_pend_d = 1'b0;

        if (rd_ok) begin
            humid_d      = drv_humid;
            temp_d       = drv_temp;
            data_valid_d = 1'b1;
            err_sticky_d = 1'b0;
            retry_cnt_d  = '0;
        end
        if (rec_exit) begin
            if (can_retry) begin
                retry_cnt_d  = retry_cnt_q + 8'd1;
                retry_pend_d = 1'b1;
            end else begin
                retry_cnt_d  = '0;
                err_sticky_d = 1'b1;
            end
        end

        drv_rst_n_d = (state_d != ST_RECOVER);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            man_prev_q   <= 1'b0;
            man_pend_q   <= 1'b0;
            auto_pend_q  <= 1'b0;
            retry_pend_q <= 1'b0;
            retry_cnt_q  <= '0;
            humid_q      <= '0;
            temp_q       <= '0;
            data_valid   <= 1'b0;
            err_sticky   <= 1'b0;
            drv_rst_n_q  <= 1'b0;
        end else begin
            man_prev_q   <= man_req;
            man_pend_q   <= man_pend_d;
            auto_pend_q  <= auto_pend_d;
            retry_pend_q <= retry_pend_d;
            retry_cnt_q  <= retry_cnt_d;
            humid_q      <= humid_d;
            temp_q       <= temp_d;
            data_valid   <= data_valid_d;
            err_sticky   <= err_sticky_d;
            drv_rst_n_q  <= drv_rst_n_d;
        end
    end

`ifdef DHT11_SCHED_STATS_EN
    logic [7:0] ok_cnt_q, err_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ok_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            if (rd_ok)   ok_cnt_q  <= sat_inc8(ok_cnt_q);
            if (rd_fail) err_cnt_q <= sat_inc8(err_cnt_q);
        end
    end

    assign ok_cnt  = ok_cnt_q;
    assign err_cnt = err_cnt_q;
`else
    assign ok_cnt  = '0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_dht11_capture_scheduler.sv
// Directed bench for dht11_capture_scheduler with shortened timing (1 ms = 4 clocks).
module tb_dht11_capture_scheduler;

    localparam int GAP = 20;
    localparam int PER = 60;
    localparam int TO  = 10;
    localparam int RST = 3;
    localparam int BUDGET = 4000;

`ifdef DHT11_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk, rst_n, tick_ms, auto_en, man_req;
    logic       drv_start, drv_rst_n, drv_done, drv_err;
    logic [7:0] drv_humid, drv_temp, humid_q, temp_q, ok_cnt, err_cnt;
    logic       data_valid, busy, err_sticky;

    int n_cmp = 0;
    int n_err = 0;
    int ms = 0;
    int n_start = 0;
    int div = 0;
    int s, f, r, last_start, raise_ms, en_ms, n0;

    dht11_capture_scheduler #(
        .MIN_GAP_MS(GAP), .AUTO_PERIOD_MS(PER), .TIMEOUT_MS(TO),
        .RST_MS(RST), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick_ms(tick_ms), .auto_en(auto_en),
        .man_req(man_req), .drv_start(drv_start), .drv_rst_n(drv_rst_n),
        .drv_done(drv_done), .drv_err(drv_err), .drv_humid(drv_humid),
        .drv_temp(drv_temp), .humid_q(humid_q), .temp_q(temp_q),
        .data_valid(data_valid), .busy(busy), .err_sticky(err_sticky),
        .ok_cnt(ok_cnt), .err_cnt(err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tick_ms = 1'b0;
        forever begin
            @(negedge clk);
            tick_ms = (div == 3);
            div = (div + 1) % 4;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) ms <= 0;
        else if (tick_ms) ms <= ms + 1;
    end

    always @(posedge clk) begin
        if (drv_start) n_start <= n_start + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_start(input int raise, input int last);
        return (raise > last + GAP) ? raise : last + GAP;
    endfunction

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!tick_ms);
        end
        @(negedge clk);
    endtask

    task automatic wait_start(input string tag, output int at);
        int k = 0;
        while (drv_start !== 1'b1 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        check(tag, drv_start, 1);
        at = ms;
    endtask

    task automatic wait_rst(input string tag, input logic level, output int at);
        int k = 0;
        while (drv_rst_n !== level && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        check(tag, drv_rst_n, level);
        at = ms;
    endtask

    task automatic pulse_done(input logic err, input logic [7:0] h, input logic [7:0] t);
        drv_done = 1'b1; drv_err = err; drv_humid = h; drv_temp = t;
        @(negedge clk);
        drv_done = 1'b0; drv_err = 1'b0;
    endtask

    // One unanswered read: start, timeout, driver reset window.
    task automatic run_timeout(input string tag, input int exp_s);
        int ts, tf, tr;
        wait_start({tag, "_start"}, ts);
        check({tag, "_start_ms"}, ts, exp_s);
        man_req = 1'b0;
        last_start = ts;
        wait_rst({tag, "_rst_lo"}, 1'b0, tf);
        check({tag, "_timeout_ms"}, tf - ts, TO);
        check({tag, "_busy_rec"}, busy, 1);
        wait_rst({tag, "_rst_hi"}, 1'b1, tr);
        check({tag, "_rst_len"}, tr - tf, RST);
    endtask

    initial begin
        rst_n = 1'b0; auto_en = 1'b0; man_req = 1'b0;
        drv_done = 1'b0; drv_err = 1'b0; drv_humid = '0; drv_temp = '0;
        last_start = 0;
        repeat (3) @(negedge clk);
        check("rst_drv_start", drv_start, 0);
        check("rst_drv_rst_n", drv_rst_n, 0);
        check("rst_humid", humid_q, 0);
        check("rst_temp", temp_q, 0);
        check("rst_valid", data_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sticky", err_sticky, 0);
        check("rst_ok_cnt", ok_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_drv_rst_n", drv_rst_n, 1);

        // Manual request during power-up settle waits for the gap
        wait_ticks(5);
        raise_ms = ms;
        man_req = 1'b1;
        wait_start("a_start", s);
        check("a_start_ms", s, exp_start(raise_ms, last_start));
        man_req = 1'b0;
        last_start = s;
        @(negedge clk);
        check("a_one_pulse", drv_start, 0);
        check("a_busy", busy, 1);
        wait_ticks(3);
        pulse_done(1'b0, 8'h37, 8'h19);
        check("a_humid", humid_q, 8'h37);
        check("a_temp", temp_q, 8'h19);
        check("a_valid", data_valid, 1);
        check("a_busy_done", busy, 0);
        pulse_done(1'b0, 8'hAA, 8'hBB);
        check("a_stray_done", humid_q, 8'h37);
        wait_ticks(30);
        check("a_n_start", n_start, 1);

        // Periodic capture
        auto_en = 1'b1;
        en_ms = ms;
        wait_start("b_start1", s);
        check("b_start1_ms", s, en_ms + PER);
        last_start = s;
        wait_ticks(5);
        pulse_done(1'b0, 8'h28, 8'h1A);
        check("b_humid1", humid_q, 8'h28);
        check("b_temp1", temp_q, 8'h1A);
        wait_start("b_start2", s);
        check("b_period", s - last_start, PER);
        last_start = s;
        wait_ticks(5);
        pulse_done(1'b0, 8'h2D, 8'h1B);
        check("b_humid2", humid_q, 8'h2D);
        check("b_temp2", temp_q, 8'h1B);
        auto_en = 1'b0;

        // Checksum error once, then a good retry
        raise_ms = ms;
        man_req = 1'b1;
        wait_start("d_start", s);
        check("d_start_ms", s, exp_start(raise_ms, last_start));
        man_req = 1'b0;
        last_start = s;
        wait_ticks(3);
        pulse_done(1'b1, 8'h00, 8'h00);
        wait_rst("d_rst_lo", 1'b0, f);
        check("d_busy_rec", busy, 1);
        wait_rst("d_rst_hi", 1'b1, r);
        check("d_rst_len", r - f, RST);
        check("d_sticky_mid", err_sticky, 0);
        wait_start("d_retry", s);
        check("d_retry_ms", s, last_start + GAP);
        last_start = s;
        wait_ticks(4);
        pulse_done(1'b0, 8'h30, 8'h16);
        check("d_humid", humid_q, 8'h30);
        check("d_temp", temp_q, 8'h16);
        check("d_sticky", err_sticky, 0);
        check("d_busy", busy, 0);
        check("d_ok_cnt", ok_cnt, STATS ? 4 : 0);
        check("d_err_cnt", err_cnt, STATS ? 1 : 0);

        // Manual edge on the same tick as the auto wrap: one capture
        n0 = n_start;
        auto_en = 1'b1;
        en_ms = ms;
        wait_ticks(PER - 1);
        repeat (3) @(negedge clk);
        man_req = 1'b1;
        wait_start("e_start", s);
        check("e_start_ms", s, en_ms + PER);
        man_req = 1'b0;
        last_start = s;
        wait_ticks(4);
        pulse_done(1'b0, 8'h33, 8'h17);
        wait_ticks(25);
        check("e_single", n_start, n0 + 1);
        auto_en = 1'b0;

        // Driver never answers: two retries then give up
        n0 = n_start;
        raise_ms = ms;
        man_req = 1'b1;
        run_timeout("c0", exp_start(raise_ms, last_start));
        check("c0_sticky", err_sticky, 0);
        run_timeout("c1", last_start + GAP);
        run_timeout("c2", last_start + GAP);
        check("c_sticky", err_sticky, 1);
        check("c_busy", busy, 0);
        check("c_humid_kept", humid_q, 8'h33);
        wait_ticks(30);
        check("c_attempts", n_start, n0 + 3);
        check("c_ok_cnt", ok_cnt, STATS ? 5 : 0);
        check("c_err_cnt", err_cnt, STATS ? 4 : 0);

        // Reset in the middle of a read
        raise_ms = ms;
        man_req = 1'b1;
        wait_start("f_start", s);
        man_req = 1'b0;
        wait_ticks(2);
        check("f_busy_pre", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("f_busy", busy, 0);
        check("f_drv_start", drv_start, 0);
        check("f_drv_rst_n", drv_rst_n, 0);
        check("f_valid", data_valid, 0);
        check("f_humid", humid_q, 0);
        check("f_sticky", err_sticky, 0);
        check("f_ok_cnt", ok_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("f_rel_rst_n", drv_rst_n, 1);
        pulse_done(1'b0, 8'h55, 8'h66);
        check("f_stale_valid", data_valid, 0);
        check("f_stale_humid", humid_q, 0);
        check("f_stale_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dht11_capture_scheduler.md
Name: dht11_capture_scheduler

Overview:
Sequences every DHT11 acquisition on the Elbert V2 board. It merges manual button requests and a periodic auto-capture timer into a single start stream and enforces the sensor's minimum inter-read gap. It supervises each read with a timeout, resets the driver and retries on failure, and latches the last good humidity/temperature pair for the display mux. It sits between the debounced buttons and mode select on one side and the DHT11 driver on the other.

Parameters:
MIN_GAP_MS, 2000, minimum ms from one drv_start to the next; also the power-up settle delay after reset
AUTO_PERIOD_MS, 8000, auto-capture interval in ms while auto_en=1
TIMEOUT_MS, 50, maximum ms from drv_start to drv_done before the read is declared failed
RST_MS, 5, ms that drv_rst_n is held low during recovery
MAX_RETRY, 2, retries after a failed read before the request is dropped

Ports:
clk  in  1  system clock (12 MHz)
rst_n  in  1  synchronous active-low reset
tick_ms  in  1  one-clk strobe, once per ms
auto_en  in  1  level; enables periodic capture
man_req  in  1  debounced button level; its rising edge is the request
drv_start  out  1  one-clk start pulse to driver
drv_rst_n  out  1  active-low driver reset
drv_done  in  1  one-clk pulse from driver, read finished
drv_err  in  1  qualifies drv_done: 1 = checksum/protocol error
drv_humid  in  8  driver humidity byte, valid with drv_done
drv_temp  in  8  driver temperature byte, valid with drv_done
humid_q  out  8  last good humidity
temp_q  out  8  last good temperature
data_valid  out  1  high once any good read has been latched
busy  out  1  high from drv_start until read resolved, including recovery
err_sticky  out  1  set when a request is dropped after retries; cleared by next good read
ok_cnt  out  8  good-read count (STATS_EN)
err_cnt  out  8  failed-attempt count (STATS_EN)

Behaviour:
- Reset (rst_n=0 at posedge clk): state=IDLE; drv_start=0; drv_rst_n=0; humid_q=temp_q=0; data_valid=0; busy=0; err_sticky=0; pending flags=0; gap_cnt=0; auto_cnt=0; retry_cnt=0; counters=0. drv_rst_n goes 1 on the first clk after reset release.
- man_req edge detect: a registered previous value; a rising edge sets man_pend. Edges arriving in any state are latched.
- auto_cnt (16 bit): counts tick_ms while auto_en=1. At AUTO_PERIOD_MS-1 it wraps to 0 and sets auto_pend. auto_en=0 clears auto_cnt and auto_pend.
- gap_cnt (16 bit): saturates at MIN_GAP_MS and is cleared on each drv_start. gap_ok = (gap_cnt==MIN_GAP_MS). The first read after reset therefore waits MIN_GAP_MS.
- FSM states: IDLE, START, WAIT, RECOVER.
- IDLE: if (man_pend|auto_pend|retry_pend) and gap_ok, go to START. Otherwise hold; requests remain pending.
- START: drv_start=1 for exactly this one cycle; clear man_pend, auto_pend and retry_pend; load to_cnt=0; busy=1; next state WAIT. Simultaneous man and auto requests produce one capture.
- WAIT: to_cnt increments on tick_ms.
  - drv_done & ~drv_err: latch humid_q/temp_q the same edge; data_valid=1; err_sticky=0; retry_cnt=0; busy=0; go to IDLE.
  - drv_done & drv_err, or to_cnt==TIMEOUT_MS: go to RECOVER.
  - drv_done on the same cycle as the timeout: drv_done wins.
- RECOVER: drv_rst_n=0 for RST_MS ticks, then released.
  - If retry_cnt<MAX_RETRY: retry_cnt+1, set retry_pend.
  - Else: retry_cnt=0, err_sticky=1.
  - busy=0 on exit; return to IDLE. Retries still obey gap_ok.
- drv_done outside WAIT is ignored.
- A request latched during WAIT/RECOVER is serviced after the current read resolves and the gap elapses.
- Reset mid-read: all state returns to reset values; the driver is reset via drv_rst_n.

Optional Feature:
- DHT11_SCHED_STATS_EN defined: ok_cnt increments on each good read; err_cnt increments on each entry to RECOVER. Both saturate at 255 and both are reset to 0.
- Undefined: ok_cnt and err_cnt are tied to 0 and no counter flops exist.

Decomposition:
- Package dht11_sched_pkg: FSM state encoding (2 bit), counter width constant CNT_W=16, default timing constants.
- One sub-module, ms_timer: tick-driven counter with clear, enable, saturate-or-wrap mode and a terminal flag. Instantiated for gap, auto, timeout and recovery timing.

Test Plan:
- Reset release, man_req pulse at 100 ms -> drv_start at first clk where gap_cnt=2000 ms; exactly one pulse.
- auto_en=1, driver answers good after 20 ms -> drv_start every 8000 ms; humid_q/temp_q equal driver bytes; data_valid=1.
- Driver never responds -> timeout at 50 ms, drv_rst_n low 5 ms, two retries each ≥2000 ms apart, then err_sticky=1, busy=0.
- drv_done&drv_err once, then good -> one retry; err_sticky stays 0; retry_cnt returns to 0; err_cnt=1, ok_cnt=1 (STATS_EN).
- man_req edge on the same tick that auto_pend sets -> single drv_start; both pendings cleared.
- rst_n low during WAIT -> next cycle state IDLE, busy=0, outputs at reset values; a stale drv_done after release is ignored.
